// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter.
// Holds the FSM state encoding, the default requester count and data width,
// and a helper that sizes requester-index fields.
package reg_write_arbiter_pkg;

  localparam int unsigned NDefault = 4;
  localparam int unsigned WDefault = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StWrite = 2'd2
  } state_e;

  // Width of an index into N requesters; at least one bit even when N == 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Searches req_i starting at ptr_i, wrapping from N-1 to 0; the first set bit wins.
// Ports:
//   req_i   - request vector (N bits)
//   ptr_i   - index at which the search starts (must be < N)
//   pick_o  - one-hot winner, all-zero when req_i is empty
//   index_o - binary index of the winner, zero when req_i is empty
module rr_picker
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N = NDefault,
  localparam int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] index_o
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    pick_o  = '0;
    index_o = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr_i < N and k < N, so one conditional subtract gives (ptr_i + k) mod N.
      sum = {1'b0, ptr_i} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(N)) begin
        sum = sum - (PW + 1)'(N);
      end
      cand = sum[PW-1:0];
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        index_o      = cand;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared register.
// Each write takes three cycles: IDLE (arbitrate), GRANT (gnt pulse, capture data),
// WRITE (reg_we pulse, advance the round-robin pointer past the winner).
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - per-requester level request (N bits)
//   wdata    - packed write data, slice i at [i*W +: W]
//   gnt      - one-hot grant pulse, high only in GRANT
//   reg_data - data to the shared register, always the captured value
//   reg_we   - load strobe to the shared register, high only in WRITE
//   busy     - high whenever the FSM is not in IDLE
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N = NDefault,
  parameter int unsigned W = WDefault
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   reg_data,
  output logic           reg_we,
  output logic           busy
);

  localparam int unsigned PW = idx_width(N);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  pick_q, pick_d;
  logic [W-1:0]  data_q, data_d;

  logic [N-1:0]  rr_pick;
  logic [PW-1:0] rr_index;

  rr_picker #(
    .N(N)
  ) u_rr_picker (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (rr_pick),
    .index_o(rr_index)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    pick_d  = pick_q;
    data_d  = data_q;
    gnt     = '0;
    reg_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          win_d   = rr_index;
          pick_d  = rr_pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        gnt    = pick_q;
        // pick_q is one-hot, so OR-ing the masked slices selects the winner's data.
        data_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
          if (pick_q[i]) begin
            data_d = data_d | wdata[i*W +: W];
          end
        end
        state_d = StWrite;
      end
      StWrite: begin
        reg_we = 1'b1;
        if (win_q == PW'(N - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + PW'(1);
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      pick_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pick_q  <= pick_d;
      data_q  <= data_d;
    end
  end

  assign reg_data = data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by
// random request/data traffic, all compared cycle by cycle against a
// timeline-based reference model.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   reg_data;
  logic           reg_we;
  logic           busy;

  reg_write_arbiter #(
    .N(N),
    .W(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .reg_data(reg_data),
    .reg_we  (reg_we),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: t is the current cycle number, g the cycle in which the
  // current winner m_w is granted (write follows in g+1).
  longint       t;
  longint       g;
  int           m_w;
  int           m_ptr;
  logic [W-1:0] m_data;
  int           dut_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    g      = -100;
    m_w    = 0;
    m_ptr  = 0;
    m_data = '0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = (t == g) ? (N'(1) << m_w) : '0;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("reg_we", 64'(reg_we), 64'(t == g + 1));
    chk("busy", 64'(busy), 64'((t == g) || (t == g + 1)));
    chk("reg_data", 64'(reg_data), 64'(m_data));
    for (int i = 0; i < N; i++) begin
      if (gnt[i] === 1'b1) dut_log.push_back(i);
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs for the next
  // rising edge, advance the model, then move to the next falling edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] wd);
    bit idle;
    check_outputs();
    req   = r;
    wdata = wd;
    idle  = !((t == g) || (t == g + 1));
    if (t == g) m_data = wd[m_w*W +: W];
    if (t == g + 1) m_ptr = (m_w + 1) % N;
    if (idle && (r != '0)) begin
      for (int k = 0; k < N; k++) begin
        if (r[(m_ptr + k) % N]) begin
          m_w = (m_ptr + k) % N;
          g   = t + 1;
          break;
        end
      end
    end
    t++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*W-1:0] wd;
    int found1;

    // Reset state.
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_we", 64'(reg_we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_data", 64'(reg_data), 64'(0));
    rst = 1'b0;
    model_reset();

    // All-request fairness from ptr=0: order 0,1,2,3,0.
    dut_log.delete();
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < N; i++) wd[i*W +: W] = $urandom();
      cycle(4'b1111, wd);
    end
    cycle(4'b0000, wd);
    chk("fair_cnt", 64'(dut_log.size()), 64'(5));
    if (dut_log.size() == 5) begin
      chk("fair_0", 64'(dut_log[0]), 64'(0));
      chk("fair_1", 64'(dut_log[1]), 64'(1));
      chk("fair_2", 64'(dut_log[2]), 64'(2));
      chk("fair_3", 64'(dut_log[3]), 64'(3));
      chk("fair_4", 64'(dut_log[4]), 64'(0));
    end
    repeat (2) cycle(4'b0000, wd);

    // Single request from requester 0.
    wd = '0;
    wd[0 +: W] = 32'h00001FFF;
    cycle(4'b0001, wd);
    chk("single_gnt", 64'(gnt), 64'(4'b0001));
    cycle(4'b0000, wd);
    chk("single_we", 64'(reg_we), 64'(1));
    chk("single_data", 64'(reg_data), 64'(32'h00001FFF));
    cycle(4'b0000, wd);
    chk("single_idle", 64'(busy), 64'(0));

    // Data isolation on requester 2; leaves ptr at 3.
    wd[2*W +: W] = 32'h001FFF00;
    cycle(4'b0100, wd);
    chk("iso_gnt", 64'(gnt), 64'(4'b0100));
    cycle(4'b0000, wd);
    wd[2*W +: W] = 32'h07E00000;
    chk("iso_we_data", 64'(reg_data), 64'(32'h001FFF00));
    cycle(4'b0000, wd);
    chk("iso_hold_data", 64'(reg_data), 64'(32'h001FFF00));

    // Wrap-around: ptr=3 with req 1001 serves 3 then 0.
    cycle(4'b1001, wd);
    chk("wrap_gnt3", 64'(gnt), 64'(4'b1000));
    cycle(4'b0001, wd);
    cycle(4'b0001, wd);
    cycle(4'b0001, wd);
    chk("wrap_gnt0", 64'(gnt), 64'(4'b0001));
    cycle(4'b0000, wd);
    cycle(4'b0000, wd);

    // Dropped request: req[1] pulses for one busy cycle only.
    dut_log.delete();
    cycle(4'b0100, wd);
    chk("drop_gnt2", 64'(gnt), 64'(4'b0100));
    cycle(4'b0010, wd);
    repeat (5) cycle(4'b0000, wd);
    found1 = 0;
    foreach (dut_log[i]) if (dut_log[i] == 1) found1++;
    chk("drop_no_gnt1", 64'(found1), 64'(0));

    // Reset during WRITE of requester 1 aborts it and keeps ptr at 0.
    cycle(4'b0010, wd);
    chk("abort_gnt1", 64'(gnt), 64'(4'b0010));
    cycle(4'b0000, wd);
    check_outputs();
    rst = 1'b1;
    #1;
    chk("abort_we", 64'(reg_we), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_data", 64'(reg_data), 64'(0));
    chk("abort_gnt", 64'(gnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(4'b1111, wd);
    chk("post_rst_gnt0", 64'(gnt), 64'(4'b0001));
    cycle(4'b0000, wd);
    cycle(4'b0000, wd);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] nr;
      for (int i = 0; i < N; i++) begin
        if (gnt[i] === 1'b1)      nr[i] = ($urandom_range(3) == 0);
        else if (req[i] === 1'b1) nr[i] = ($urandom_range(9) != 0);
        else                      nr[i] = ($urandom_range(3) == 0);
        wd[i*W +: W] = $urandom();
      end
      cycle(nr, wd);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
